// File: rtl/dtpu_input_feeder.sv
// Input feeder for a systolic array: pops FIFO words, splits them into row lanes
// and presents them either diagonally skewed or aligned, with a start/done handshake.
module dtpu_input_feeder #(
    parameter int DATA_WIDTH_MAC    = 8,
    parameter int ROWS              = 8,
    parameter int DATA_WIDTH_FIFO_IN = 64,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic                           enable,
    input  logic                           skew_en,
    input  logic [CNT_WIDTH-1:0]           n_vectors,
    input  logic                           cs_start,
    output logic                           cs_idle,
    output logic                           cs_done,
    input  logic                           infifo_is_empty,
    input  logic [DATA_WIDTH_FIFO_IN-1:0]  infifo_dout,
    output logic                           infifo_read,
    output logic [ROWS*DATA_WIDTH_MAC-1:0] row_data,
    output logic [ROWS-1:0]                row_valid,
    output logic [CNT_WIDTH-1:0]           fed_count
);

    localparam int DW  = DATA_WIDTH_MAC;
    localparam int LW  = ROWS * DATA_WIDTH_MAC;
    localparam int DCW = (ROWS > 1) ? $clog2(ROWS) : 1;

    if (LW > DATA_WIDTH_FIFO_IN) begin : g_width_check
        $error("ROWS*DATA_WIDTH_MAC exceeds DATA_WIDTH_FIFO_IN");
    end

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] n_lat;
    logic                 skew_lat;
    logic [DCW-1:0]       drain_cnt;
    logic                 rd;
    logic                 last_rd;

    // Delay line: stage k holds the word popped k+1 enabled cycles ago.
    // Lane r taps stage r when skewed, stage 0 when aligned.
    logic [LW-1:0]   data_p [ROWS];
    logic [ROWS-1:0] vld_p  [ROWS];

    assign rd      = aresetn && enable && (state == FEED) && !infifo_is_empty
                     && (fed_count < n_lat);
    assign last_rd = rd && ((fed_count + CNT_WIDTH'(1)) == n_lat);

    assign infifo_read = rd;
    assign cs_idle     = (state == IDLE);
    assign cs_done     = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cs_start) state_nx = (n_vectors == '0) ? DONE : FEED;
            FEED:    if (last_rd) state_nx = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= IDLE;
            n_lat     <= '0;
            skew_lat  <= 1'b0;
            fed_count <= '0;
            drain_cnt <= '0;
            for (int k = 0; k < ROWS; k++) begin
                data_p[k] <= '0;
                vld_p[k]  <= '0;
            end
        end else if (enable) begin
            state <= state_nx;
            if (state == IDLE && cs_start) begin
                n_lat     <= n_vectors;
                skew_lat  <= skew_en;
                fed_count <= '0;
            end else if (rd) begin
                fed_count <= fed_count + CNT_WIDTH'(1);
            end
            // Last-valid exit from lane ROWS-1 happens ROWS cycles after the final read when skewed.
            if (last_rd) begin
                drain_cnt <= skew_lat ? DCW'(ROWS - 1) : '0;
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DCW'(1);
            end
            data_p[0] <= rd ? infifo_dout[LW-1:0] : '0;
            vld_p[0]  <= {ROWS{rd}};
            for (int k = 1; k < ROWS; k++) begin
                data_p[k] <= data_p[k-1];
                vld_p[k]  <= vld_p[k-1];
            end
        end
    end

    always_comb begin
        row_data  = '0;
        row_valid = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (skew_lat) begin
                row_data[r*DW +: DW] = data_p[r][r*DW +: DW];
                row_valid[r]         = vld_p[r][r];
            end else begin
                row_data[r*DW +: DW] = data_p[0][r*DW +: DW];
                row_valid[r]         = vld_p[0][r];
            end
        end
    end

    // Bits with no consumer: the last stage's lower lanes and the FIFO bits above the lanes.
    if (ROWS > 1 && LW < DATA_WIDTH_FIFO_IN) begin : g_sink_both
        logic unused_bits;
        assign unused_bits = ^{data_p[ROWS-1][LW-DW-1:0], vld_p[ROWS-1][ROWS-2:0],
                               infifo_dout[DATA_WIDTH_FIFO_IN-1:LW]};
    end else if (ROWS > 1) begin : g_sink_tail
        logic unused_bits;
        assign unused_bits = ^{data_p[ROWS-1][LW-DW-1:0], vld_p[ROWS-1][ROWS-2:0]};
    end else if (LW < DATA_WIDTH_FIFO_IN) begin : g_sink_fifo
        logic unused_bits;
        assign unused_bits = ^infifo_dout[DATA_WIDTH_FIFO_IN-1:LW];
    end

endmodule

// File: tb/tb_dtpu_input_feeder.sv
// Randomized and directed bench for dtpu_input_feeder against a schedule-table model
// indexed by enabled clock edges.
module tb_dtpu_input_feeder;

    localparam int ROWS = 3;
    localparam int DW   = 4;
    localparam int FW   = 64;
    localparam int CW   = 16;
    localparam int TBL  = 4096;
    localparam logic [63:0] CAFE = 64'hCAFECAFECAFECAFE;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              enable;
    logic              skew_en;
    logic [CW-1:0]     n_vectors;
    logic              cs_start;
    logic              cs_idle;
    logic              cs_done;
    logic              infifo_is_empty;
    logic [FW-1:0]     infifo_dout;
    logic              infifo_read;
    logic [ROWS*DW-1:0] row_data;
    logic [ROWS-1:0]   row_valid;
    logic [CW-1:0]     fed_count;

    always #5 clk = ~clk;

    dtpu_input_feeder #(
        .DATA_WIDTH_MAC(DW), .ROWS(ROWS), .DATA_WIDTH_FIFO_IN(FW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .aresetn(aresetn), .enable(enable), .skew_en(skew_en),
        .n_vectors(n_vectors), .cs_start(cs_start), .cs_idle(cs_idle), .cs_done(cs_done),
        .infifo_is_empty(infifo_is_empty), .infifo_dout(infifo_dout),
        .infifo_read(infifo_read), .row_data(row_data), .row_valid(row_valid),
        .fed_count(fed_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference: what each lane shows after the e-th enabled edge, filled in when a pop happens.
    logic [ROWS*DW-1:0] t_data [TBL];
    logic [ROWS-1:0]    t_vld  [TBL];
    logic [63:0]        q[$];
    bit                 m_busy;
    bit                 m_skew;
    int                 m_n;
    int                 m_fed;
    int                 m_done_at;
    int                 e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < TBL; i++) begin
            t_data[i] = '0;
            t_vld[i]  = '0;
        end
    endtask

    task automatic step(input bit en, input bit st, input int nv, input bit sk,
                        input bit stall, input bit rstn);
        bit          exp_rd;
        logic [63:0] w;
        int          idx;
        enable          = en;
        cs_start        = st;
        n_vectors       = CW'(nv);
        skew_en         = sk;
        aresetn         = rstn;
        infifo_is_empty = stall || (q.size() == 0);
        infifo_dout     = (q.size() != 0) ? q[0] : 64'h0;
        #2;
        exp_rd = rstn && en && m_busy && !infifo_is_empty && (m_fed < m_n);
        check("read",  {63'd0, infifo_read}, {63'd0, exp_rd});
        check("idle",  {63'd0, cs_idle},     {63'd0, !m_busy});
        check("done",  {63'd0, cs_done},     {63'd0, (m_busy && e == m_done_at)});
        check("fed",   64'(fed_count),       64'(m_fed));
        check("data",  64'(row_data),        64'(t_data[e]));
        check("valid", 64'(row_valid),       64'(t_vld[e]));
        if (!rstn) begin
            m_busy = 0; m_fed = 0; m_n = 0; m_done_at = -1;
            clear_table();
        end else if (en) begin
            if (exp_rd) begin
                w = q.pop_front();
                for (int r = 0; r < ROWS; r++) begin
                    idx = e + 1 + (m_skew ? r : 0);
                    t_data[idx][r*DW +: DW] = w[r*DW +: DW];
                    t_vld[idx][r]           = 1'b1;
                end
                m_fed++;
                if (m_fed == m_n) m_done_at = e + 1 + (m_skew ? ROWS : 1);
            end
            if (m_busy && e == m_done_at) begin
                m_busy = 0;
            end else if (!m_busy && st) begin
                m_busy = 1; m_fed = 0; m_n = nv; m_skew = sk;
                m_done_at = (nv == 0) ? e + 1 : -1;
            end
            e++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 1);
    endtask

    task automatic finish_op(input string tag);
        for (int i = 0; i < 40 && !cs_idle; i++) step(1, 0, 0, 0, 0, 1);
        check(tag, {63'd0, cs_idle}, 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 0; enable = 0; skew_en = 0; n_vectors = '0; cs_start = 0;
        infifo_is_empty = 1; infifo_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_table();
        m_busy = 0; m_fed = 0; m_n = 0; m_done_at = -1; m_skew = 0; e = 0;

        // Skewed feed of two CAFE words
        for (int i = 0; i < 4; i++) q.push_back(CAFE);
        step(1, 1, 2, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("sk_t1_data", 64'(row_data), 64'h00E); check("sk_t1_vld", 64'(row_valid), 64'b001);
        step(1, 0, 0, 0, 0, 1);
        check("sk_t2_data", 64'(row_data), 64'h0FE); check("sk_t2_vld", 64'(row_valid), 64'b011);
        step(1, 0, 0, 0, 0, 1);
        check("sk_t3_data", 64'(row_data), 64'hAF0); check("sk_t3_vld", 64'(row_valid), 64'b110);
        step(1, 0, 0, 0, 0, 1);
        check("sk_t4_data", 64'(row_data), 64'hA00); check("sk_t4_vld", 64'(row_valid), 64'b100);
        step(1, 0, 0, 0, 0, 1);
        check("sk_t5_done", {63'd0, cs_done}, 64'd1);
        step(1, 0, 0, 0, 0, 1);
        q.delete();

        // Aligned feed
        for (int i = 0; i < 4; i++) q.push_back(CAFE);
        step(1, 1, 2, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("al_t1_data", 64'(row_data), 64'hAFE); check("al_t1_vld", 64'(row_valid), 64'b111);
        step(1, 0, 0, 0, 0, 1);
        check("al_t2_data", 64'(row_data), 64'hAFE); check("al_t2_vld", 64'(row_valid), 64'b111);
        step(1, 0, 0, 0, 0, 1);
        check("al_t3_done", {63'd0, cs_done}, 64'd1);
        step(1, 0, 0, 0, 0, 1);
        q.delete();

        // Starvation mid-run
        for (int i = 0; i < 4; i++) q.push_back({$urandom, $urandom});
        step(1, 1, 4, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1);
        check("starve_fed", 64'(fed_count), 64'd1);
        finish_op("starve_end");
        check("starve_total", 64'(fed_count), 64'd4);

        // Zero-length start, then a start while busy
        step(1, 1, 0, 1, 0, 1);
        check("zero_done", {63'd0, cs_done}, 64'd1);
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) q.push_back({$urandom, $urandom});
        step(1, 1, 3, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 7, 1, 0, 1);
        finish_op("busy_end");
        check("busy_fed", 64'(fed_count), 64'd3);
        q.delete();

        // Enable held low mid-feed
        for (int i = 0; i < 6; i++) q.push_back({$urandom, $urandom});
        step(1, 1, 4, 1, 0, 1);
        run(2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        finish_op("en_end");
        check("en_fed", 64'(fed_count), 64'd4);
        q.delete();

        // Reset in DRAIN
        q.push_back({$urandom, $urandom});
        step(1, 1, 1, 1, 0, 1);
        run(2);
        step(1, 0, 0, 0, 0, 0);
        check("rst_idle",  {63'd0, cs_idle},   64'd1);
        check("rst_valid", 64'(row_valid),     64'd0);
        check("rst_fed",   64'(fed_count),     64'd0);
        check("rst_done",  {63'd0, cs_done},   64'd0);
        run(4);
        q.delete();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit en, st, sk, stall, rstn;
            int nv;
            if (q.size() < 4) q.push_back({$urandom, $urandom});
            en    = ($urandom_range(0, 9) != 0);
            st    = (!m_busy && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
            nv    = $urandom_range(0, 6);
            sk    = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 4) == 0);
            rstn  = ($urandom_range(0, 99) != 0);
            step(en, st, nv, sk, stall, rstn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtpu_input_feeder.md
DTPU_INPUT_FEEDER -- requirements
Module: dtpu_input_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH_MAC, default 8, bits per MAC operand lane.
REQ-002 SHALL have parameter ROWS, default 8, number of systolic-array row lanes.
REQ-003 SHALL have parameter DATA_WIDTH_FIFO_IN, default 64, input FIFO word width; ROWS*DATA_WIDTH_MAC <= DATA_WIDTH_FIFO_IN is required, checked at elaboration.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, vector-count width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port aresetn, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port enable, input, 1, global advance; low freezes all state.
REQ-008 SHALL have port skew_en, input, 1, 1 = diagonal skew, 0 = all lanes aligned; sampled on start.
REQ-009 SHALL have port n_vectors, input, CNT_WIDTH, vectors to feed; sampled on start.
REQ-010 SHALL have port cs_start, input, 1, start request.
REQ-011 SHALL have port cs_idle, output, 1, high in IDLE.
REQ-012 SHALL have port cs_done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port infifo_is_empty, input, 1, FIFO empty flag.
REQ-014 SHALL have port infifo_dout, input, DATA_WIDTH_FIFO_IN, first-word-fall-through head data.
REQ-015 SHALL have port infifo_read, output, 1, pop strobe.
REQ-016 SHALL have port row_data, output, ROWS*DATA_WIDTH_MAC, lane r at bits [r*DW +: DW].
REQ-017 SHALL have port row_valid, output, ROWS, per-lane valid.
REQ-018 SHALL have port fed_count, output, CNT_WIDTH, vectors popped since start.

Function
REQ-019 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-020 SHALL move IDLE->FEED on cs_start=1 with n_vectors!=0; capture n_vectors, skew_en; clear fed_count.
REQ-021 SHALL move IDLE->DONE on cs_start=1 with n_vectors=0; no FIFO read.
REQ-022 SHALL ignore cs_start outside IDLE.
REQ-023 SHALL assert infifo_read combinationally iff state=FEED, enable=1, infifo_is_empty=0, fed_count<n_vectors latched.
REQ-024 SHALL never assert infifo_read when infifo_is_empty=1.
REQ-025 SHALL increment fed_count on each read; FEED->DRAIN in the cycle the final read occurs.
REQ-026 SHALL split a popped word into lanes: lane r = infifo_dout[r*DW +: DW]; upper unused bits discarded.
REQ-027 SHALL, with skew_en=1, present lane r of a word read at cycle t at cycle t+1+r with row_valid[r]=1.
REQ-028 SHALL, with skew_en=0, present all lanes of a word read at cycle t at cycle t+1.
REQ-029 SHALL insert a bubble (valid=0, data=0) into lane 0 in any enabled FEED cycle without a read (FIFO empty); bubbles propagate down the skew chain like data.
REQ-030 SHALL hold DRAIN until the last valid leaves lane ROWS-1 (ROWS cycles after last read if skewed, 1 if not), then go to DONE.
REQ-031 SHALL assert cs_done for exactly one cycle in DONE, then return to IDLE.
REQ-032 SHALL, when enable=0, hold FSM, counters, row_data, row_valid and deassert infifo_read.
REQ-033 SHALL drive row_valid=0 and row_data=0 on any lane without valid data.

Reset
REQ-034 SHALL, when aresetn=0 at a clk edge, enter IDLE, clear fed_count, skew pipeline, row_data, row_valid, cs_done; cs_idle=1, infifo_read=0.
REQ-035 SHALL abort any in-flight operation on reset without cs_done and without further FIFO reads.

Verification (ROWS=3, DATA_WIDTH_MAC=4, DATA_WIDTH_FIFO_IN=64)
REQ-036 SHALL verify skewed feed: n_vectors=2, skew_en=1, infifo_dout=64'hCAFECAFECAFECAFE, never empty -> reads at t0,t0+1; lane0=E at t0+1, lane1=F at t0+2, lane2=A at t0+3; cs_done at t0+5.
REQ-037 SHALL verify aligned feed: same stimulus, skew_en=0 -> row_data=12'hAFE, row_valid=3'b111 at t0+1, t0+2; cs_done at t0+3.
REQ-038 SHALL verify FIFO starvation: infifo_is_empty=1 for 3 cycles mid-run -> infifo_read=0, bubble visible on lane0 then lanes 1,2; fed_count frozen; completes with fed_count=n_vectors.
REQ-039 SHALL verify zero-length and busy start: n_vectors=0 -> cs_done the cycle after start, no read; cs_start during FEED -> no effect on counts.
REQ-040 SHALL verify enable=0 for 4 cycles mid-FEED -> all outputs held, infifo_read=0, resume with correct ordering.
REQ-041 SHALL verify aresetn=0 mid-DRAIN -> next cycle cs_idle=1, row_valid=0, fed_count=0, no cs_done.
